// File: rtl/adder_rr_scheduler_if.sv
// Requester-side bus for the shared adder scheduler.
//   req       : per-requester request level
//   a_in/b_in : packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt       : one-hot grant pulse
//   busy      : scheduler not idle
//   sum_out   : registered WIDTH+1-bit sum
//   sum_valid : one-cycle pulse qualifying sum_out/sum_id
//   sum_id    : requester index owning sum_out
// The master modport is the requester side; the slave modport is the scheduler.
interface adder_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic [WIDTH:0]           sum_out;
  logic                     sum_valid;
  logic [IDW-1:0]           sum_id;

  modport master (
    output req, a_in, b_in,
    input  gnt, busy, sum_out, sum_valid, sum_id
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, busy, sum_out, sum_valid, sum_id
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit adder between NUM_REQ requesters.
// One operation is in flight at a time: IDLE (arbitrate, capture operands)
// -> EXEC (grant visible, add) -> DONE (result valid) -> IDLE.
// Ports:
//   clk : system clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : adder_rr_scheduler_if.slave (req/a_in/b_in in; gnt/busy/sum_out/
//         sum_valid/sum_id out)
module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst,
  adder_rr_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_nxt;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   win_idx;
  logic             win_found;

  logic [WIDTH-1:0] op_a_p0;
  logic [WIDTH-1:0] op_b_p0;
  logic [WIDTH:0]   sum_p1;
  logic [IDW-1:0]   id_p1;
  logic             vld_p1;

  // Zero-extending add: the carry lands in the extra result bit.
  function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] k);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Search starts just after the last winner, so the previous winner has the
  // lowest priority on the next round.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: operand capture at the IDLE->EXEC edge ----
  always_ff @(posedge clk) begin
    if (state == IDLE && win_found) begin
      op_a_p0 <= bus.a_in[win_idx*WIDTH +: WIDTH];
      op_b_p0 <= bus.b_in[win_idx*WIDTH +: WIDTH];
    end
  end

  // Pointer only moves on a grant; after the grant it names the owner of the
  // operation in flight, which EXEC uses for both gnt and the result tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDW'(NUM_REQ - 1);
    end else if (state == IDLE && win_found) begin
      ptr <= win_idx;
    end
  end

  // ---- stage p1: registered sum and tag, written on the EXEC->DONE edge ----
  // The result registers are cleared by reset because the visible outputs
  // must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1 <= '0;
      id_p1  <= '0;
    end else if (state == EXEC) begin
      sum_p1 <= add_ext(op_a_p0, op_b_p0);
      id_p1  <= ptr;
    end
  end

  assign vld_p1 = (state == DONE);

  assign bus.gnt       = (state == EXEC) ? onehot(ptr) : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.sum_out   = sum_p1;
  assign bus.sum_valid = vld_p1;
  assign bus.sum_id    = id_p1;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
module tb_adder_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passes = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  adder_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  adder_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int k, input logic [3:0] a, input logic [3:0] b);
    bus.a_in[k*WIDTH +: WIDTH] = a;
    bus.b_in[k*WIDTH +: WIDTH] = b;
  endtask

  // req must already be driven; the next edge is the IDLE sample.
  task automatic op(input string tag, input int k, input logic [4:0] sum);
    step();
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(1 << k));
    check({tag, ".busy_exec"}, 32'(bus.busy), 32'd1);
    check({tag, ".vld_exec"}, 32'(bus.sum_valid), 32'd0);
    step();
    check({tag, ".vld"}, 32'(bus.sum_valid), 32'd1);
    check({tag, ".sum"}, 32'(bus.sum_out), 32'(sum));
    check({tag, ".id"}, 32'(bus.sum_id), 32'(k));
    check({tag, ".gnt_done"}, 32'(bus.gnt), 32'd0);
    step();
    check({tag, ".vld_off"}, 32'(bus.sum_valid), 32'd0);
    check({tag, ".sum_hold"}, 32'(bus.sum_out), 32'(sum));
    check({tag, ".id_hold"}, 32'(bus.sum_id), 32'(k));
  endtask

  initial begin
    logic [4:0] exp_sum [4];
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst.gnt", 32'(bus.gnt), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.vld", 32'(bus.sum_valid), 32'd0);
    check("rst.sum", 32'(bus.sum_out), 32'd0);
    check("rst.id", 32'(bus.sum_id), 32'd0);
    step();
    check("idle_noreq.busy", 32'(bus.busy), 32'd0);

    // T1: 0xF + 0x1 = 0x10 with carry kept
    set_ops(0, 4'hF, 4'h1);
    bus.req = 4'b0001;
    op("t1", 0, 5'h10);
    bus.req = '0;

    // T2: all requesting, fresh reset so order starts at 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_ops(0, 4'd2, 4'd5);   exp_sum[0] = 5'd7;
    set_ops(1, 4'd5, 4'd6);   exp_sum[1] = 5'd11;
    set_ops(2, 4'd8, 4'd7);   exp_sum[2] = 5'd15;
    set_ops(3, 4'd11, 4'd8);  exp_sum[3] = 5'd19;
    bus.req = 4'b1111;
    for (int i = 0; i < 12; i++) op($sformatf("t2.%0d", i), i % 4, exp_sum[i % 4]);

    // T3: ptr=3, req=1001 -> 0 then 3
    bus.req = 4'b1001;
    op("t3a", 0, 5'd7);
    op("t3b", 3, 5'd19);
    bus.req = '0;
    step();

    // T4: 0xF + 0xF = 30
    set_ops(2, 4'hF, 4'hF);
    bus.req = 4'b0100;
    op("t4", 2, 5'd30);
    bus.req = '0;
    step();

    // T6: operands changed during EXEC are ignored; req bits raised outside
    // IDLE are ignored and dropped before the next IDLE sample.
    set_ops(1, 4'd3, 4'd4);
    bus.req = 4'b0010;
    step();
    check("t6.gnt", 32'(bus.gnt), 32'b0010);
    set_ops(1, 4'hF, 4'hF);
    bus.req = 4'b1000;
    step();
    bus.req = '0;
    check("t6.vld", 32'(bus.sum_valid), 32'd1);
    check("t6.sum", 32'(bus.sum_out), 32'd7);
    check("t6.id", 32'(bus.sum_id), 32'd1);
    step();
    step();
    check("t6.no_regrant", 32'(bus.gnt), 32'd0);
    check("t6.idle", 32'(bus.busy), 32'd0);

    // T5: reset during EXEC discards the operation
    set_ops(0, 4'hF, 4'h1);
    bus.req = 4'b0001;
    step();
    check("t5.gnt", 32'(bus.gnt), 32'b0001);
    rst = 1'b1;
    bus.req = '0;
    step();
    rst = 1'b0;
    check("t5.gnt0", 32'(bus.gnt), 32'd0);
    check("t5.busy", 32'(bus.busy), 32'd0);
    check("t5.vld", 32'(bus.sum_valid), 32'd0);
    check("t5.sum", 32'(bus.sum_out), 32'd0);
    check("t5.id", 32'(bus.sum_id), 32'd0);
    step();
    check("t5.vld_later", 32'(bus.sum_valid), 32'd0);
    // ptr back at NUM_REQ-1: requester 0 wins against 1 and 3
    set_ops(0, 4'd9, 4'd9);
    bus.req = 4'b1011;
    op("t5.ptr", 0, 5'd18);
    bus.req = '0;
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
